intr_req_ctl: RTL and testbench

- Interrupt request collector feeding the flag/condition stage's `sintr` input.
- Synchronizes and edge-detects external device request lines, holds per-source pending and enable bits, and selects a fixed-priority vector.
- Drives `sintr` through a small request/acknowledge FSM. Microcode acknowledges and programs it through the destination-write path, qualified by `state_fetch`.

---
 rtl/intr_req_ctl.sv | 175 +++++++++++++++++
 tb/tb_intr_req_ctl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/intr_req_ctl.sv
// intr_req_ctl: interrupt request collector driving the flag stage's sintr input.
// Synchronizes and edge-detects device request lines, keeps per-source pending and
// enable bits, picks the lowest-numbered active source and presents it through a
// request/acknowledge FSM (IDLE -> REQ -> HOLD -> IDLE).
// Optional feature: define INTR_TIMER_EN to add an interval timer as source NSRC.
module intr_req_ctl #(
  parameter int unsigned NSRC    = 8,
  parameter int unsigned TIMER_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            state_fetch,
  input  logic            ack,
  input  logic            wr_en,
  input  logic [1:0]      wr_sel,
  input  logic [31:0]     wr_data,
  output logic            sintr,
  output logic [3:0]      vector,
  output logic [31:0]     rd_data
);

`ifdef INTR_TIMER_EN
  localparam int unsigned NB = NSRC + 1;
`else
  localparam int unsigned NB = NSRC;
`endif

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e          state_q;
  logic            sintr_q;
  logic [3:0]      vector_q;
  logic [NSRC-1:0] sync1_q, sync2_q, prev_q;
  logic [NSRC-1:0] rise;
  logic [NB-1:0]   en_q, pending_q, pending_d;
  logic [NB-1:0]   set_mask, w1c_mask, ack_mask, vec_onehot, active;
  logic [3:0]      sel_idx;
  logic            any_active;
  logic            fetch_wr, ack_fire, w1c_hit;
  logic            timer_tick;
  logic            unused_wr;

  assign unused_wr = ^wr_data;
  assign fetch_wr  = state_fetch & wr_en;
  assign ack_fire  = (state_q == StReq) & state_fetch & ack;
  assign rise      = sync2_q & ~prev_q;
  assign active    = pending_q & en_q;

  // Two-flop synchronizer plus previous-value flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

`ifdef INTR_TIMER_EN
  logic [TIMER_W-1:0] reload_q, cnt_q;

  assign timer_tick = (reload_q != '0) && (cnt_q == TIMER_W'(1));

  // Interval timer: counts reload..1, then fires and reloads; reload==0 parks it at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q <= '0;
      cnt_q    <= '0;
    end else if (fetch_wr && wr_sel == 2'd2) begin
      reload_q <= wr_data[TIMER_W-1:0];
      cnt_q    <= wr_data[TIMER_W-1:0];
    end else if (reload_q == '0) begin
      cnt_q <= '0;
    end else if (cnt_q <= TIMER_W'(1)) begin
      cnt_q <= reload_q;
    end else begin
      cnt_q <= cnt_q - TIMER_W'(1);
    end
  end
`else
  assign timer_tick = 1'b0;
`endif

  // Set/clear masks; the currently presented vector as a one-hot mask
  always_comb begin
    set_mask = '0;
    set_mask[NSRC-1:0] = rise;
`ifdef INTR_TIMER_EN
    set_mask[NSRC] = timer_tick;
`endif
    w1c_mask = (fetch_wr && wr_sel == 2'd1) ? wr_data[NB-1:0] : '0;
    vec_onehot = '0;
    for (int i = 0; i < int'(NB); i++) begin
      vec_onehot[i] = (vector_q == 4'(i));
    end
    ack_mask = ack_fire ? vec_onehot : '0;
    // Set wins over a same-cycle clear so a fresh request is never lost
    pending_d = (pending_q & ~(w1c_mask | ack_mask)) | set_mask;
    w1c_hit   = (|(w1c_mask & vec_onehot)) && !(|(pending_d & vec_onehot));
  end

  // Fixed priority: lowest-numbered active source wins
  always_comb begin
    any_active = 1'b0;
    sel_idx    = '0;
    for (int i = int'(NB) - 1; i >= 0; i--) begin
      if (active[i]) begin
        any_active = 1'b1;
        sel_idx    = 4'(i);
      end
    end
  end

  // Enable and pending registers
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= '0;
      pending_q <= '0;
    end else begin
      if (fetch_wr && wr_sel == 2'd0) begin
        en_q <= wr_data[NB-1:0];
      end
      pending_q <= pending_d;
    end
  end

  // Request/acknowledge FSM with registered sintr and vector
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sintr_q  <= 1'b0;
      vector_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_active) begin
            vector_q <= sel_idx;
            sintr_q  <= 1'b1;
            state_q  <= StReq;
          end
        end
        StReq: begin
          // Vector stays frozen until acknowledged or its pending bit is cleared
          if (ack_fire || w1c_hit) begin
            sintr_q <= 1'b0;
            state_q <= StHold;
          end
        end
        StHold: begin
          state_q <= StIdle;
        end
        default: begin
          sintr_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sintr  = sintr_q;
  assign vector = vector_q;

  // Status word: enables in [14:0], pending in [29:15], sintr in [30]
  always_comb begin
    rd_data = '0;
    rd_data[NB-1:0] = en_q;
    rd_data[15+NB-1:15] = pending_q;
    rd_data[30] = sintr_q;
  end

endmodule

// File: tb/tb_intr_req_ctl.sv
// Self-checking bench for intr_req_ctl: directed stimulus pushes expected vectors
// into a queue; a monitor pops and compares whenever sintr rises.
module tb_intr_req_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        state_fetch, ack, wr_en;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic        sintr;
  logic [3:0]  vector;
  logic [31:0] rd_data;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic       sintr_prev = 1'b0;

  intr_req_ctl #(.NSRC(8), .TIMER_W(16)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .state_fetch(state_fetch), .ack(ack),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .sintr(sintr), .vector(vector),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: each rising edge of sintr must present the next expected vector
  always @(negedge clk) begin
    if (sintr === 1'b1 && sintr_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_request", {28'b0, vector}, 32'hFFFF_FFFF);
      end else begin
        chk("vector_on_request", {28'b0, vector}, {28'b0, exp_q.pop_front()});
      end
    end
    sintr_prev = sintr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    state_fetch = 1'b1; wr_en = 1'b1; wr_sel = sel; wr_data = d;
    tick();
    state_fetch = 1'b0; wr_en = 1'b0; wr_sel = 2'd0; wr_data = '0;
  endtask

  task automatic do_ack();
    state_fetch = 1'b1; ack = 1'b1;
    tick();
    state_fetch = 1'b0; ack = 1'b0;
  endtask

  task automatic wait_sintr(input string name, input int max);
    int n = 0;
    while (sintr !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(name, {31'b0, sintr}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; state_fetch = 1'b0; ack = 1'b0;
    wr_en = 1'b0; wr_sel = 2'd0; wr_data = '0;
    ticks(2);
    chk("reset_sintr", {31'b0, sintr}, 32'd0);
    chk("reset_vector", {28'b0, vector}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    reset = 1'b0;
    tick();

    // Single source: 3-cycle sync latency, then 1-cycle request latency
    wr(2'd0, 32'hFF);
    chk("en_readback", rd_data, 32'h0000_00FF);
    exp_q.push_back(4'd5);
    irq_in[5] = 1'b1;
    ticks(3);
    chk("pend5_after_sync", {17'b0, rd_data[29:15]}, 32'h20);
    chk("sintr_low_at_pend", {31'b0, sintr}, 32'd0);
    tick();
    chk("sintr_after_pend", {31'b0, sintr}, 32'd1);
    chk("vector5", {28'b0, vector}, 32'd5);
    do_ack();
    chk("hold_after_ack5", {31'b0, sintr}, 32'd0);
    chk("pend_cleared_ack5", {17'b0, rd_data[29:15]}, 32'd0);
    ticks(6);
    chk("level_no_reset", {31'b0, sintr}, 32'd0);
    irq_in = '0;
    ticks(2);

    // Two sources together: lowest index first
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd6);
    irq_in[6] = 1'b1; irq_in[2] = 1'b1;
    ticks(3);
    chk("pend_6_2", {17'b0, rd_data[29:15]}, 32'h44);
    tick();
    chk("vector2", {28'b0, vector}, 32'd2);
    do_ack();
    chk("hold_after_ack2", {31'b0, sintr}, 32'd0);
    chk("hold_vector_kept", {28'b0, vector}, 32'd2);
    wait_sintr("req6", 4);
    chk("vector6", {28'b0, vector}, 32'd6);
    do_ack();
    irq_in = '0;
    ticks(3);

    // Vector frozen in REQ when a higher-priority source arrives
    exp_q.push_back(4'd4);
    irq_in[4] = 1'b1;
    ticks(4);
    chk("vector4", {28'b0, vector}, 32'd4);
    exp_q.push_back(4'd1);
    irq_in[1] = 1'b1;
    ticks(5);
    chk("frozen_vector4", {28'b0, vector}, 32'd4);
    chk("frozen_sintr", {31'b0, sintr}, 32'd1);
    chk("pend1_while_req", {31'b0, rd_data[16]}, 32'd1);
    do_ack();
    chk("hold_after_ack4", {31'b0, sintr}, 32'd0);
    wait_sintr("req1", 4);
    chk("vector1", {28'b0, vector}, 32'd1);
    do_ack();
    irq_in = '0;
    ticks(3);

    // Disabled source stays pending; enabling it raises the request; W1C retracts it
    wr(2'd0, 32'h00);
    irq_in[3] = 1'b1;
    ticks(4);
    chk("pend3_disabled", {31'b0, rd_data[18]}, 32'd1);
    chk("no_req_disabled", {31'b0, sintr}, 32'd0);
    exp_q.push_back(4'd3);
    wr(2'd0, 32'h08);
    tick();
    chk("req_after_enable", {31'b0, sintr}, 32'd1);
    chk("vector3", {28'b0, vector}, 32'd3);
    wr(2'd1, 32'h08);
    chk("w1c_drops_sintr", {31'b0, sintr}, 32'd0);
    chk("w1c_clears_pend3", {31'b0, rd_data[18]}, 32'd0);
    tick();
    chk("idle_after_w1c_hold", {31'b0, sintr}, 32'd0);
    irq_in = '0;
    ticks(2);

    // Same-cycle set and W1C: set wins
    wr(2'd0, 32'h00);
    irq_in[0] = 1'b1;
    ticks(2);
    wr(2'd1, 32'h01);
    chk("set_beats_clear", {31'b0, rd_data[15]}, 32'd1);
    exp_q.push_back(4'd0);
    wr(2'd0, 32'h01);
    wait_sintr("req0", 3);
    irq_in = '0;
    tick();
    reset = 1'b1;
    tick();
    chk("reset_mid_req_sintr", {31'b0, sintr}, 32'd0);
    chk("reset_mid_req_vector", {28'b0, vector}, 32'd0);
    chk("reset_mid_req_rd", rd_data, 32'd0);
    reset = 1'b0;
    ticks(2);

`ifdef INTR_TIMER_EN
    // Interval timer as source 8: fires 5 cycles after a reload of 5
    wr(2'd0, 32'h100);
    wr(2'd2, 32'd5);
    ticks(5);
    chk("timer_pend8", {31'b0, rd_data[23]}, 32'd1);
    chk("timer_sintr_low", {31'b0, sintr}, 32'd0);
    exp_q.push_back(4'd8);
    tick();
    chk("timer_sintr", {31'b0, sintr}, 32'd1);
    chk("timer_vector8", {28'b0, vector}, 32'd8);
    wr(2'd2, 32'd0);
    wr(2'd1, 32'h100);
    ticks(20);
    chk("timer_stopped_pend", {31'b0, rd_data[23]}, 32'd0);
    chk("timer_stopped_sintr", {31'b0, sintr}, 32'd0);
`endif

    ticks(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
